// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and types for the 1-to-4 stream demux.
// Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] ch_sel_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry output slot with a wrapping transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Data needs no reset: it is only observed while the slot is full.
    always_ff @(posedge clk) begin
        if (load) begin
            r_data <= load_data;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_xfer      = (r_state == SLOT_FULL) && ready;
        case (r_state)
            SLOT_EMPTY: if (load) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (w_xfer && !load) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    assign valid = (r_state == SLOT_FULL);
    assign data  = r_data;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/demux_1_4_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_1_4_stream
// Description : Routes a valid/ready input stream to one of four buffered
//               output channels selected by in_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1_4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  ch_sel_t          in_sel,
    output logic [N_CH-1:0]  out_valid,
    input  logic [N_CH-1:0]  out_ready,
    output logic [WIDTH-1:0] out_data  [N_CH],
    output logic [CNT_W-1:0] out_count [N_CH]
);

    logic [N_CH-1:0] w_load;
    logic            w_ready;

    // Ready depends only on the selected slot, never on in_valid.
    always_comb begin
        w_ready = !out_valid[in_sel] || out_ready[in_sel];
        w_load  = '0;
        if (in_valid && w_ready) begin
            w_load[in_sel] = 1'b1;
        end
    end

    assign in_ready = w_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (w_load[i]),
            .load_data(in_data),
            .ready    (out_ready[i]),
            .valid    (out_valid[i]),
            .data     (out_data[i]),
            .count    (out_count[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1_4_stream
// Description : Self-checking bench: vector table, corner sequences and a
//               four-queue scoreboard under random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1_4_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data  [4];
    logic [7:0]   out_count [4];

    demux_1_4_stream #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [3:0] d;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t         tbl [8];
    logic [W-1:0] q [4][$];
    logic [7:0]   mcnt [4];
    logic         prev_stall [4];
    logic [W-1:0] prev_data [4];
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Checks the current cycle against the model at the falling edge, then
    // advances the model by what the coming rising edge will do.
    task automatic step(input logic tbl_en, input logic tbl_rdy);
        logic mrdy;
        @(negedge clk);
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                q[c].delete();
                mcnt[c] = '0;
                prev_stall[c] = 1'b0;
            end
        end else begin
            mrdy = (q[in_sel].size() == 0) || out_ready[in_sel];
            chk("in_ready", {31'd0, in_ready}, {31'd0, mrdy});
            if (tbl_en) chk("tbl_in_ready", {31'd0, in_ready}, {31'd0, tbl_rdy});
            for (int c = 0; c < 4; c++) begin
                chk("out_valid", {31'd0, out_valid[c]}, {31'd0, q[c].size() != 0});
                chk("out_count", {24'd0, out_count[c]}, {24'd0, mcnt[c]});
                if (prev_stall[c]) chk("stall_data", {28'd0, out_data[c]}, {28'd0, prev_data[c]});
                prev_stall[c] = (q[c].size() != 0) && !out_ready[c];
                prev_data[c]  = out_data[c];
                if (q[c].size() != 0 && out_ready[c]) begin
                    chk("out_data", {28'd0, out_data[c]}, {28'd0, q[c][0]});
                    void'(q[c].pop_front());
                    mcnt[c] = mcnt[c] + 8'd1;
                end
            end
            if (in_valid && mrdy) q[in_sel].push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    initial begin
        tbl[0] = '{1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100};
        tbl[1] = '{1'b1, 2'd2, 4'hB, 4'b0000, 1'b0, 4'b0100};
        tbl[2] = '{1'b1, 2'd1, 4'hC, 4'b0000, 1'b1, 4'b0110};
        tbl[3] = '{1'b1, 2'd3, 4'h5, 4'b0000, 1'b1, 4'b1110};
        tbl[4] = '{1'b1, 2'd3, 4'h6, 4'b1000, 1'b1, 4'b1110};
        tbl[5] = '{1'b0, 2'd2, 4'hF, 4'b0100, 1'b1, 4'b1010};
        tbl[6] = '{1'b0, 2'd0, 4'h0, 4'b1010, 1'b1, 4'b0000};
        tbl[7] = '{1'b1, 2'd0, 4'h7, 4'b1111, 1'b1, 4'b0001};

        rst = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        @(posedge clk); #1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 4; c++) chk("rst_count", {24'd0, out_count[c]}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
            step(1'b1, tbl[i].exp_rdy);
            chk("tbl_out_valid", {28'd0, out_valid}, {28'd0, tbl[i].exp_ov});
            if (i == 0) begin
                chk("first_data2", {28'd0, out_data[2]}, 32'hA);
                chk("first_count2", {24'd0, out_count[2]}, 32'd0);
            end
            if (i == 4) begin
                chk("drain_load_data3", {28'd0, out_data[3]}, 32'h6);
                chk("drain_load_count3", {24'd0, out_count[3]}, 32'd1);
            end
        end

        // Fill every slot, then reset mid-operation with all consumers ready.
        for (int c = 1; c < 4; c++) begin
            drive(1'b1, 2'(c), 4'(c + 8), 4'b0000);
            step(1'b0, 1'b0);
        end
        chk("fill_out_valid", {28'd0, out_valid}, 32'hF);
        rst = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        step(1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 2'd0, 4'h0, 4'b0000);
        chk("midrst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 4; c++) chk("midrst_count", {24'd0, out_count[c]}, 32'd0);

        // 256 back-to-back words to channel 0; the counter must wrap to 0.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'd0, 4'(i * 7 + 3), 4'b1111);
            step(1'b1, 1'b1);
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        step(1'b0, 1'b0);
        chk("stream_count0", {24'd0, out_count[0]}, 32'd0);
        chk("stream_empty", {28'd0, out_valid}, 32'd0);

        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step(1'b0, 1'b0);
        end
        drive(1'b0, 2'd0, 4'h0, 4'b1111);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("final_empty", {28'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
